// File: rtl/alu_pkg.sv
// Shared select codes, FSM state encoding and legality check for the ALU arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_MUL = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // True for the six operations the external ALU implements.
  function automatic logic alu_sel_legal(input logic [3:0] sel);
    case (sel)
      ALU_AND, ALU_OR, ALU_ADD, ALU_MUL, ALU_SUB, ALU_SLT: return 1'b1;
      default:                                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-input round-robin grant: a lone requester wins, a tie goes to the port not granted last.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is used.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // One-hot grant; on a tie the port opposite last_grant wins.
  always_comb begin
    grant = 2'b00;
    if (valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external single-cycle ALU between two requesters with round-robin arbitration.
// Latency: 2 edges from request accept to response valid; one operation per 2 cycles at best.
// Backpressure: a pending response stalls all new requests until its port's ready is seen.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_op1,
  input  logic [WIDTH-1:0] req0_op2,
  input  logic [SEL_W-1:0] req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_op1,
  input  logic [WIDTH-1:0] req1_op2,
  input  logic [SEL_W-1:0] req1_sel,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic             rsp1_err,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_result
);

  state_e                  state_q, state_d;
  logic                    last_q, last_d;
  logic                    gnt_q, gnt_d;
  logic [WIDTH-1:0]        op1_q, op1_d, op2_q, op2_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [1:0]              rsp_vld_q, rsp_vld_d;
  logic [1:0][WIDTH-1:0]   res_q, res_d;
  logic [1:0]              zero_q, zero_d;
  logic [1:0]              err_q, err_d;

  logic [1:0] req_vld;
  logic [1:0] rsp_rdy;
  logic [1:0] arb_gnt;
  logic [1:0] req_rdy;
  logic       arb_last;
  logic       rsp_hs;
  logic       can_accept;
  logic       accept;

  assign req_vld = {req1_valid, req0_valid};
  assign rsp_rdy = {rsp1_ready, rsp0_ready};

  // Response handshake of the operation currently held in RESP.
  assign rsp_hs = (state_q == ST_RESP) && rsp_vld_q[gnt_q] && rsp_rdy[gnt_q];

  // While completing in RESP, the completing port already counts as last granted.
  assign arb_last = (state_q == ST_RESP) ? gnt_q : last_q;

  rr_arb2 u_arb (
    .valid      (req_vld),
    .last_grant (arb_last),
    .grant      (arb_gnt)
  );

  assign can_accept = (state_q == ST_IDLE) || rsp_hs;
  assign req_rdy    = (can_accept && !reset) ? arb_gnt : 2'b00;
  assign accept     = |req_rdy;

  // Next-state logic: operand capture on accept, result capture in ISSUE, release in RESP.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    sel_d     = sel_q;
    rsp_vld_d = rsp_vld_q;
    res_d     = res_q;
    zero_d    = zero_q;
    err_d     = err_q;

    if (accept) begin
      gnt_d = req_rdy[1];
      op1_d = req_rdy[1] ? req1_op1 : req0_op1;
      op2_d = req_rdy[1] ? req1_op2 : req0_op2;
      sel_d = req_rdy[1] ? req1_sel : req0_sel;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        rsp_vld_d[gnt_q] = 1'b1;
        if (alu_sel_legal(sel_q)) begin
          res_d[gnt_q]  = alu_result;
          zero_d[gnt_q] = (alu_result == '0);
          err_d[gnt_q]  = 1'b0;
        end else begin
          res_d[gnt_q]  = '0;
          zero_d[gnt_q] = 1'b1;
          err_d[gnt_q]  = 1'b1;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_hs) begin
          rsp_vld_d[gnt_q] = 1'b0;
          last_d           = gnt_q;
          state_d          = accept ? ST_ISSUE : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, ALU input and response registers; reset discards any in-flight work.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;
      gnt_q     <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      sel_q     <= '0;
      rsp_vld_q <= '0;
      res_q     <= '0;
      zero_q    <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      sel_q     <= sel_d;
      rsp_vld_q <= rsp_vld_d;
      res_q     <= res_d;
      zero_q    <= zero_d;
      err_q     <= err_d;
    end
  end

  assign req0_ready  = req_rdy[0];
  assign req1_ready  = req_rdy[1];
  assign rsp0_valid  = rsp_vld_q[0];
  assign rsp1_valid  = rsp_vld_q[1];
  assign rsp0_result = res_q[0];
  assign rsp1_result = res_q[1];
  assign rsp0_zero   = zero_q[0];
  assign rsp1_zero   = zero_q[1];
  assign rsp0_err    = err_q[0];
  assign rsp1_err    = err_q[1];
  assign alu_op1     = op1_q;
  assign alu_op2     = op2_q;
  assign alu_sel     = sel_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios then random traffic, checked by a scoreboard monitor.
// Latency: expects responses 2 edges after accept.
// Backpressure: randomizes response ready and checks request stalls against a served-port model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [3:0]  req0_sel, req1_sel;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;
  logic [31:0] alu_op1, alu_op2, alu_result;
  logic [3:0]  alu_sel;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .SEL_W(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_sel(req1_sel),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel), .alu_result(alu_result)
  );

  // Reference arithmetic: {err, result}; illegal selects expect result 0.
  function automatic logic [32:0] ref_op(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (s)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = (a < b) ? 32'd1 : 32'd0;
      4'b0011: r = a * b;
      default: return {1'b1, 32'd0};
    endcase
    return {1'b0, r};
  endfunction

  // External ALU model; illegal codes produce garbage that the DUT must suppress.
  logic [32:0] alu_ref;
  assign alu_ref    = ref_op(alu_sel, alu_op1, alu_op2);
  assign alu_result = alu_ref[32] ? (32'hDEAD_BEEF ^ alu_op1) : alu_ref[31:0];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        port;
    logic        err;
    logic [31:0] res;
  } exp_t;

  exp_t expq[$];
  int   pend[2];
  logic last_model;

  logic [1:0] q_vld, q_rdy, r_vld, r_rdy;
  assign q_vld = {req1_valid, req0_valid};
  assign q_rdy = {req1_ready, req0_ready};
  assign r_vld = {rsp1_valid, rsp0_valid};
  assign r_rdy = {rsp1_ready, rsp0_ready};

  // Monitor: scoreboard responses, latency, and expected request readiness.
  always @(negedge clk) begin
    logic [1:0]  hs, exp_rdy;
    logic        eff_last, in_issue, blocked;
    logic [32:0] t;
    exp_t        e;
    if (reset) begin
      chk("ready_in_reset", 32'(q_rdy), 32'd0);
      chk("rsp_valid_in_reset", 32'(r_vld), 32'd0);
      expq.delete();
      pend[0] = 0;
      pend[1] = 0;
      last_model = 1'b1;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (pend[p] != 0) begin
          pend[p]--;
          if (pend[p] == 1) chk("rsp_early", 32'(r_vld[p]), 32'd0);
          else              chk("rsp_latency", 32'(r_vld[p]), 32'd1);
        end
      end
      hs = r_vld & r_rdy;
      for (int p = 0; p < 2; p++) begin
        if (r_vld[p]) begin
          if (expq.size() == 0 || expq[0].port != p[0]) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: port %0d valid with no matching expected entry", p);
          end else begin
            e = expq[0];
            chk(p == 0 ? "rsp0_result" : "rsp1_result", p == 0 ? rsp0_result : rsp1_result, e.res);
            chk(p == 0 ? "rsp0_zero" : "rsp1_zero", 32'(p == 0 ? rsp0_zero : rsp1_zero), 32'(e.res == 32'd0));
            chk(p == 0 ? "rsp0_err" : "rsp1_err", 32'(p == 0 ? rsp0_err : rsp1_err), 32'(e.err));
            if (hs[p]) void'(expq.pop_front());
          end
        end
      end
      eff_last = hs[0] ? 1'b0 : (hs[1] ? 1'b1 : last_model);
      in_issue = (pend[0] == 1) || (pend[1] == 1);
      blocked  = in_issue || (|(r_vld & ~r_rdy));
      if (blocked)             exp_rdy = 2'b00;
      else if (q_vld == 2'b11) exp_rdy = eff_last ? 2'b01 : 2'b10;
      else                     exp_rdy = q_vld;
      chk("req_ready", 32'(q_rdy), 32'(exp_rdy));
      if (hs != 2'b00) last_model = hs[1];
      for (int p = 0; p < 2; p++) begin
        if (q_vld[p] && q_rdy[p]) begin
          t = (p == 0) ? ref_op(req0_sel, req0_op1, req0_op2) : ref_op(req1_sel, req1_op1, req1_op2);
          e.port = p[0];
          e.err  = t[32];
          e.res  = t[31:0];
          expq.push_back(e);
          pend[p] = 2;
        end
      end
    end
  end

  task automatic set_req(input int p, input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    if (p == 0) begin req0_valid = 1'b1; req0_sel = s; req0_op1 = a; req0_op2 = b; end
    else        begin req1_valid = 1'b1; req1_sel = s; req1_op1 = a; req1_op2 = b; end
  endtask

  // Hold presented requests until accepted; returns just after the last accept edge.
  task automatic drain();
    logic [1:0] acc;
    int n;
    n = 0;
    while ((req0_valid || req1_valid) && n < 100) begin
      @(negedge clk);
      acc = q_vld & q_rdy;
      @(posedge clk);
      #1;
      if (acc[0]) req0_valid = 1'b0;
      if (acc[1]) req1_valid = 1'b0;
      n++;
    end
    if (req0_valid || req1_valid) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: requests %b never accepted", q_vld);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
  endtask

  function automatic logic [3:0] rand_sel();
    case ($urandom % 8)
      0: return 4'b0000;
      1: return 4'b0001;
      2: return 4'b0010;
      3: return 4'b0110;
      4: return 4'b0111;
      5: return 4'b0011;
      default: return 4'($urandom);
    endcase
  endfunction

  initial begin
    logic [1:0]  acc;
    logic [31:0] a, b;
    reset = 1'b1;
    req0_valid = 1'b1; req0_sel = 4'b0010; req0_op1 = 32'd1; req0_op2 = 32'd2;
    req1_valid = 1'b0; req1_sel = 4'b0; req1_op1 = 32'd0; req1_op2 = 32'd0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_alu_sel", 32'(alu_sel), 32'd0);
    chk("reset_alu_op1", alu_op1, 32'd0);
    chk("reset_alu_op2", alu_op2, 32'd0);
    chk("reset_rsp0_result", rsp0_result, 32'd0);
    chk("reset_rsp1_result", rsp1_result, 32'd0);
    chk("reset_zero_err", 32'({rsp1_zero, rsp0_zero, rsp1_err, rsp0_err}), 32'd0);
    req0_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_ready", 32'(q_rdy), 32'd0);

    set_req(0, 4'b0010, 32'd5, 32'd7);
    drain();
    repeat (4) @(posedge clk); #1;

    // Tie after reset, then re-present the tie once port 1 was served last.
    for (int k = 0; k < 2; k++) begin
      set_req(0, 4'b0110, 32'd9, 32'd9);
      set_req(1, 4'b0001, 32'h0000_00F0, 32'h0000_000F);
      drain();
      repeat (4) @(posedge clk); #1;
    end

    // Backpressure on port 0 while port 1 waits.
    rsp0_ready = 1'b0;
    set_req(0, 4'b0010, 32'd100, 32'd23);
    drain();
    set_req(1, 4'b0111, 32'd3, 32'd5);
    repeat (5) @(posedge clk);
    #1;
    chk("bp_req1_waiting", 32'(req1_valid), 32'd1);
    rsp0_ready = 1'b1;
    drain();
    repeat (4) @(posedge clk); #1;

    set_req(1, 4'b1111, 32'd123, 32'd456);
    drain();
    repeat (3) @(posedge clk); #1;
    set_req(0, 4'b0011, 32'h0001_0000, 32'h0001_0000);
    drain();
    repeat (3) @(posedge clk); #1;

    // Reset while the port 0 operation is in ISSUE.
    set_req(0, 4'b0010, 32'd1, 32'd1);
    drain();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("no_rsp_after_reset", 32'(rsp0_valid), 32'd0);
    end
    @(posedge clk); #1;
    set_req(0, 4'b0000, 32'h0000_FF00, 32'h0000_0FF0);
    drain();
    repeat (4) @(posedge clk); #1;

    // Random traffic with random response backpressure.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      acc = q_vld & q_rdy;
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
        if (acc[p] || !q_vld[p]) begin
          if ($urandom % 3 != 0) begin
            a = ($urandom % 2 == 1) ? $urandom : ($urandom % 16);
            b = ($urandom % 4 == 0) ? a : (($urandom % 2 == 1) ? $urandom : ($urandom % 16));
            set_req(p, rand_sel(), a, b);
          end else if (p == 0) begin
            req0_valid = 1'b0;
          end else begin
            req1_valid = 1'b0;
          end
        end
      end
      rsp0_ready = ($urandom % 4 != 0);
      rsp1_ready = ($urandom % 4 != 0);
    end
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    drain();
    repeat (8) @(posedge clk);
    #1;
    chk("scoreboard_empty", expq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle 32-bit integer ALU between two requesters: port 0 is the execute stage and port 1 is the branch/address unit. Each port issues operations over a valid/ready request channel and receives the result over a valid/ready response channel. The block arbitrates round-robin, registers operands into the ALU, and captures the result and a zero flag. The ALU itself is instantiated outside this block and connected through the `alu_*` ports.

## Interface
- `WIDTH`, 32, operand and result width
- `SEL_W`, 4, ALU select width
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req0_valid` / `req1_valid`  in  1  request present
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle
- `req0_op1`, `req0_op2` / `req1_op1`, `req1_op2`  in  WIDTH  operands
- `req0_sel` / `req1_sel`  in  SEL_W  ALU operation code
- `rsp0_valid` / `rsp1_valid`  out  1  response present
- `rsp0_ready` / `rsp1_ready`  in  1  response consumed
- `rsp0_result` / `rsp1_result`  out  WIDTH  ALU result
- `rsp0_zero` / `rsp1_zero`  out  1  result equals 0
- `rsp0_err` / `rsp1_err`  out  1  illegal select code
- `alu_op1`, `alu_op2`  out  WIDTH  registered operands to the ALU
- `alu_sel`  out  SEL_W  registered select to the ALU
- `alu_result`  in  WIDTH  combinational ALU result

## Operation
- Legal select codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 SLT (unsigned compare, result 1 or 0)
  - 0011 MUL (low 32 bits)
- All other select codes are illegal.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any `reqN_valid` is high, grant one port and raise only that port's `reqN_ready`, combinationally in the same cycle.
  - Latch operands, select and grant id into the `alu_*` registers; move to ISSUE.
- ISSUE:
  - The ALU computes from the registered inputs.
  - On the next edge, capture `alu_result` into the granted port's response registers.
  - `zero` = (result == 0), computed internally.
  - Set `rspN_valid`; move to RESP.
- RESP:
  - Hold `rspN_valid`, `result`, `zero` and `err` stable until `rspN_ready` is high.
  - On handshake: clear `rspN_valid` and update `last_grant`.
  - If any request is valid in that same cycle, arbitrate and accept it (RESP → ISSUE).
  - Otherwise go to IDLE.
- Round-robin arbitration:
  - If only one port is valid, it wins.
  - If both are valid, the port not equal to `last_grant` wins.
  - `last_grant` resets to 1, so port 0 wins the first tie.
- `reqN_ready` is 0 in ISSUE and in RESP without a handshake; a request is never accepted while a response is pending.
- Illegal select:
  - The request is accepted normally and the ALU input registers are loaded.
  - Captured result is forced to 0, with `zero` = 1 and `err` = 1.
- Only the granted port's response registers change; the other port's response registers retain their value.

## Timing
- Accept at edge N: ISSUE during cycle N→N+1; `rspN_valid` high after edge N+1. Latency is 2 edges.
- Back-to-back throughput with `rsp_ready` tied high: one operation per 2 cycles.
- Reset values: all `rsp*_valid`, `rsp*_result`, `rsp*_zero` and `rsp*_err` = 0; `alu_op1` = `alu_op2` = 0; `alu_sel` = 0000; state = IDLE; `last_grant` = 1.
- `reqN_ready` is 0 while `reset` is high.
- Reset mid-operation: any in-flight or pending response is discarded with no partial handshake. The first request after reset deassertion is served normally.
- Simultaneous response handshake and new request in RESP: both happen on the same edge; arbitration uses `last_grant` already updated for the completing operation.
- MUL wraps to the low 32 bits, e.g. 0x0001_0000 × 0x0001_0000 gives result 0 with `zero` = 1.
- ADD and SUB wrap modulo 2^32.

## Structure
- Package `alu_pkg`:
  - Select constants `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLT`, `ALU_MUL`.
  - Function `alu_sel_legal`.
  - FSM state enum.
- Sub-module `rr_arb2`: two-input round-robin grant. Inputs: `valid[1:0]`, `last_grant`. Output: one-hot `grant[1:0]`. Purely combinational.
- Top level: FSM, ALU input registers, two response register sets.

## Test plan
- Reset held 3 cycles → all `rsp*_valid` = 0, `req*_ready` = 0, `alu_sel` = 0000; after release, idle outputs remain 0.
- Port 0 ADD 5 + 7 → `req0_ready` high for 1 cycle; `rsp0_valid` rises 2 edges later with result 12, `zero` = 0, `err` = 0.
- Both ports valid after reset: port 0 SUB 9 − 9, port 1 OR 0xF0 | 0x0F → port 0 is served first (result 0, `zero` = 1), then port 1 (0xFF). Re-present both → port 0 wins again, since `last_grant` = 1.
- Backpressure: `rsp0_ready` low for 5 cycles while port 1 requests SLT 3 < 5 → `rsp0` is held stable and `req1_ready` stays 0. When `rsp0_ready` rises, port 1 is accepted on the same edge and `rsp1` later returns 1.
- Illegal select 4'b1111 on port 1 → `rsp1_result` = 0, `zero` = 1, `err` = 1. MUL 0x10000 × 0x10000 → result 0, `zero` = 1, `err` = 0.
- Reset asserted in ISSUE after port 0 accept → no `rsp0_valid` is produced. After release, port 0 AND 0xFF00 & 0x0FF0 → 0x0F00.
